tic_timer_arbiter: RTL and testbench
====================================

TIC_TIMER_ARBITER -- requirements
Module: tic_timer_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters.
REQ-002 SHALL have parameter DW, default 8, width of each duration field.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port tic, input, 1, one-cycle timebase pulse from the tick counter (m_counter).
REQ-006 SHALL have port req, input, N, per-requester level request; held high until done or abort.
REQ-007 SHALL have port dur, input, N*DW, duration in tics; requester i uses bits [i*DW +: DW].
REQ-008 SHALL have port gnt, output, N, one-hot grant to the current timer owner; all-zero when idle.
REQ-009 SHALL have port done, output, N, one-cycle pulse to the owner when its duration expires.
REQ-010 SHALL have port aborted, output, 1, one-cycle pulse when the owner drops req before expiry.
REQ-011 SHALL have port busy, output, 1, high while in state RUN or DONE.
REQ-012 SHALL have port remaining, output, DW, current down-counter value; 0 when idle.

Function
REQ-013 SHALL implement a single shared tic-driven down-counter, owned by at most one requester at a time.
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 In IDLE with req != 0, SHALL select a winner round-robin, searching from index ptr upward and wrapping at N-1 -> 0.
- On that same edge: gnt = one-hot(winner), cnt <= dur[winner].
- Next state: RUN if dur[winner] != 0; DONE if dur[winner] == 0.
REQ-016 Latency: gnt SHALL assert on the first rising edge after req is seen in IDLE.
REQ-017 SHALL sample dur only at grant; later changes to dur SHALL be ignored until the next grant.
REQ-018 In RUN, on tic with cnt > 1: cnt <= cnt - 1.
REQ-019 In RUN, on tic with cnt == 1: cnt <= 0 and next state DONE.
REQ-020 In RUN with no tic, cnt SHALL hold.
REQ-021 In DONE, SHALL hold for exactly one cycle, during which:
- done[owner] = 1 and gnt stays asserted;
- on exit, gnt is cleared, ptr <= (owner+1) mod N, next state IDLE.
REQ-022 Abort: in RUN with req[owner] == 0, SHALL pulse aborted for one cycle, clear gnt and cnt, set ptr <= (owner+1) mod N, and go to IDLE; no done pulse.
REQ-023 If abort and terminal tic (cnt == 1) occur in the same cycle, abort SHALL win.
REQ-024 A req drop during DONE SHALL be ignored; the done pulse still occurs.
REQ-025 After DONE or abort, a new grant SHALL occur no earlier than the cycle following the return to IDLE; one idle cycle between owners is mandatory.
REQ-026 Requests from non-owners during RUN or DONE SHALL be held pending without effect.
REQ-027 Worst-case wait for any continuously requesting requester SHALL be N-1 complete grants.
REQ-028 Counter arithmetic SHALL be unsigned DW-bit and SHALL never underflow below 0.
REQ-029 done, aborted and gnt SHALL be registered outputs; remaining = cnt.

Reset
REQ-030 On rst low, SHALL immediately set state=IDLE, gnt=0, done=0, aborted=0, busy=0, cnt=0, ptr=0, regardless of clock.
REQ-031 Reset mid-RUN SHALL discard the operation with no done or aborted pulse.
REQ-032 The first grant after rst rises SHALL follow REQ-015 with ptr=0.

Verification
REQ-033 Single request: req=4'b0001, dur0=3, tic every 10 clk -> gnt=0001 next edge, remaining 3->2->1->0 on tics, done[0] one cycle after 3rd tic, then gnt=0.
REQ-034 Zero duration: req=0010, dur1=0 -> gnt=0010, next cycle done[1]=1, no tic needed, then IDLE.
REQ-035 Round-robin: req=1111 held, all dur=1 -> grant order 0,1,2,3,0, with one idle cycle between owners.
REQ-036 Abort: req=0100, dur2=5, drop req2 after 2 tics -> aborted=1 one cycle, no done[2], gnt=0, next winner is index 3.
REQ-037 Abort vs terminal tic: dur=1, req dropped on the same cycle as tic -> aborted=1, done=0.
REQ-038 Async reset: assert rst low mid-RUN between clock edges -> gnt, busy and remaining read 0 immediately; after release, req=1000 -> gnt=1000.

Source files
------------

// File: rtl/tic_timer_arbiter.sv
// Round-robin arbiter that lends a single tic-driven down-counter to one requester at a time.
// The owner holds the timer until its duration expires (done pulse) or it drops req (aborted pulse).
module tic_timer_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tic,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] dur,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic            aborted,
    output logic            busy,
    output logic [DW-1:0]   remaining
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   own_q, own_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic            ab_q, ab_d;
    logic            busy_q, busy_d;

    logic            win_vld;
    logic [IW-1:0]   win_idx;
    logic [DW-1:0]   win_dur;
    logic [IW-1:0]   own_nxt;

    // First requester at or after ptr, wrapping from N-1 back to 0
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!win_vld && req[IW'((32'(ptr_q) + i) % N)]) begin
                win_vld = 1'b1;
                win_idx = IW'((32'(ptr_q) + i) % N);
            end
        end
    end

    assign win_dur = dur[32'(win_idx) * DW +: DW];
    assign own_nxt = (32'(own_q) == N - 1) ? '0 : own_q + IW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ab_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    own_d = win_idx;
                    gnt_d = N'(1) << win_idx;
                    cnt_d = win_dur;
                    if (win_dur == '0) begin
                        state_d = DONE;
                        done_d  = N'(1) << win_idx;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // A dropped request takes priority over a terminal tic
                if (!req[own_q]) begin
                    ab_d    = 1'b1;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = own_nxt;
                    state_d = IDLE;
                end else if (tic) begin
                    if (cnt_q <= DW'(1)) begin
                        cnt_d   = '0;
                        done_d  = gnt_q;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - DW'(1);
                    end
                end
            end
            DONE: begin
                gnt_d   = '0;
                cnt_d   = '0;
                ptr_d   = own_nxt;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ab_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign aborted   = ab_q;
    assign busy      = busy_q;
    assign remaining = cnt_q;

endmodule

// File: tb/tb_tic_timer_arbiter.sv
// Bench for tic_timer_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a transaction-level reference model.
module tb_tic_timer_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            tic;
    logic [N-1:0]    req;
    logic [N*DW-1:0] dur;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            aborted;
    logic            busy;
    logic [DW-1:0]   remaining;

    tic_timer_arbiter #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .tic       (tic),
        .req       (req),
        .dur       (dur),
        .gnt       (gnt),
        .done      (done),
        .aborted   (aborted),
        .busy      (busy),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a falling edge; applies inputs, lets one rising edge pass, returns at the next falling edge
    task automatic drive_cycle(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic t);
        req = r;
        dur = d;
        tic = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [N*DW-1:0] mk_dur(input int d3, input int d2, input int d1, input int d0);
        return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endfunction

    typedef struct {
        logic [N-1:0]    req;
        logic [N*DW-1:0] dur;
        logic            tic;
        logic [N-1:0]    gnt;
        logic [N-1:0]    done;
        logic            ab;
        logic            busy;
        logic [DW-1:0]   rem;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic t,
                       input logic [N-1:0] g, input logic [N-1:0] dn, input logic a,
                       input logic b, input logic [DW-1:0] rm);
        vec_t v;
        v.req = r; v.dur = d; v.tic = t;
        v.gnt = g; v.done = dn; v.ab = a; v.busy = b; v.rem = rm;
        vt.push_back(v);
    endtask

    // Reference model: who owns the timer, how many tics are left, and whether it has finished
    int          m_owner;
    int          m_left;
    int          m_ptr;
    bit          m_fin;
    int unsigned exp_done;
    int unsigned exp_ab;

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_ptr = 0; m_fin = 1'b0; exp_done = 0; exp_ab = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic t);
        bit found;
        exp_done = 0;
        exp_ab   = 0;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                if (!found && r[(m_ptr + k) % N]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_left = int'(d[m_owner*DW +: DW]);
                m_fin  = (m_left == 0);
                if (m_fin) exp_done = 1 << m_owner;
            end
        end else if (m_fin) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_fin   = 1'b0;
            m_left  = 0;
        end else if (!r[m_owner]) begin
            exp_ab  = 1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_left  = 0;
        end else if (t) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_fin    = 1'b1;
                exp_done = 1 << m_owner;
            end
        end
    endtask

    logic [N*DW-1:0] d3v, zv, ov, av, a9v, fv, rd;
    logic [N-1:0]    rr;
    logic            rt;
    int              w;

    initial begin
        rst = 1'b0; req = '0; dur = '0; tic = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.gnt", gnt, 0);
        chk("reset.done", done, 0);
        chk("reset.aborted", aborted, 0);
        chk("reset.busy", busy, 0);
        chk("reset.remaining", remaining, 0);
        rst = 1'b1;
        @(negedge clk);

        d3v = mk_dur(0, 0, 0, 3);
        zv  = mk_dur(7, 7, 0, 7);
        ov  = mk_dur(1, 1, 1, 1);
        av  = mk_dur(2, 5, 0, 0);
        a9v = mk_dur(2, 9, 0, 0);
        fv  = mk_dur(0, 0, 0, 1);

        // single request, dur0=3
        add(4'b0001, d3v, 0, 4'b0001, 4'b0000, 0, 1, 3);
        add(4'b0001, d3v, 1, 4'b0001, 4'b0000, 0, 1, 2);
        add(4'b0001, d3v, 0, 4'b0001, 4'b0000, 0, 1, 2);
        add(4'b0001, d3v, 1, 4'b0001, 4'b0000, 0, 1, 1);
        add(4'b0001, d3v, 1, 4'b0001, 4'b0001, 0, 1, 0);
        add(4'b0001, d3v, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(4'b0000, d3v, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // zero duration, ptr now 1
        add(4'b0010, zv, 0, 4'b0010, 4'b0010, 0, 1, 0);
        add(4'b0010, zv, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(4'b0000, zv, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // all requesting with ptr 2: order 2,3,0,1 with an idle cycle between
        for (int i = 0; i < 4; i++) begin
            w = (2 + i) % 4;
            add(4'b1111, ov, 1, 4'(1 << w), 4'b0000, 0, 1, 1);
            add(4'b1111, ov, 1, 4'(1 << w), 4'(1 << w), 0, 1, 0);
            add(4'b1111, ov, 1, 4'b0000, 4'b0000, 0, 0, 0);
        end
        add(4'b0000, ov, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // abort after 2 tics; dur change mid-run ignored
        add(4'b0100, av, 0, 4'b0100, 4'b0000, 0, 1, 5);
        add(4'b0100, a9v, 1, 4'b0100, 4'b0000, 0, 1, 4);
        add(4'b0100, a9v, 1, 4'b0100, 4'b0000, 0, 1, 3);
        add(4'b0000, av, 0, 4'b0000, 4'b0000, 1, 0, 0);
        add(4'b1100, av, 0, 4'b1000, 4'b0000, 0, 1, 2);
        // abort on the terminal tic wins
        add(4'b1100, av, 1, 4'b1000, 4'b0000, 0, 1, 1);
        add(4'b0100, av, 1, 4'b0000, 4'b0000, 1, 0, 0);
        add(4'b0100, av, 0, 4'b0100, 4'b0000, 0, 1, 5);
        add(4'b0000, av, 0, 4'b0000, 4'b0000, 1, 0, 0);
        add(4'b0000, av, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // wrap from ptr 3 to 0; req drop during DONE has no effect
        add(4'b0001, fv, 0, 4'b0001, 4'b0000, 0, 1, 1);
        add(4'b0001, fv, 1, 4'b0001, 4'b0001, 0, 1, 0);
        add(4'b0000, fv, 0, 4'b0000, 4'b0000, 0, 0, 0);

        foreach (vt[i]) begin
            drive_cycle(vt[i].req, vt[i].dur, vt[i].tic);
            chk($sformatf("v%0d.gnt", i), gnt, vt[i].gnt);
            chk($sformatf("v%0d.done", i), done, vt[i].done);
            chk($sformatf("v%0d.aborted", i), aborted, vt[i].ab);
            chk($sformatf("v%0d.busy", i), busy, vt[i].busy);
            chk($sformatf("v%0d.remaining", i), remaining, vt[i].rem);
        end

        // asynchronous reset between clock edges in the middle of a run
        drive_cycle(4'b0001, mk_dur(0, 0, 0, 50), 0);
        chk("arst.pre_gnt", gnt, 4'b0001);
        #2 rst = 1'b0;
        #1;
        chk("arst.gnt", gnt, 0);
        chk("arst.busy", busy, 0);
        chk("arst.remaining", remaining, 0);
        chk("arst.done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(4'b1000, mk_dur(2, 0, 0, 0), 0);
        chk("arst.post_gnt", gnt, 4'b1000);
        chk("arst.post_rem", remaining, 2);

        // round robin from a fresh reset: 0,1,2,3,0
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            drive_cycle(4'b1111, ov, 1);
            w = (c / 3) % 4;
            if (c % 3 == 2) chk($sformatf("rr%0d.gnt", c), gnt, 0);
            else chk($sformatf("rr%0d.gnt", c), gnt, 1 << w);
            chk($sformatf("rr%0d.done", c), done, (c % 3 == 1) ? (1 << w) : 0);
        end

        // random traffic against the reference model
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        rr = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (exp_done[i]) rr[i] = 1'b0;
                else if (!rr[i] && $urandom_range(0, 3) == 0) rr[i] = 1'b1;
                else if (rr[i] && $urandom_range(0, 39) == 0) rr[i] = 1'b0;
                rd[i*DW +: DW] = 8'($urandom_range(0, 4));
            end
            rt = ($urandom_range(0, 2) == 0);
            drive_cycle(rr, rd, rt);
            model_step(rr, rd, rt);
            chk($sformatf("rnd%0d.gnt", c), gnt, (m_owner < 0) ? 0 : (1 << m_owner));
            chk($sformatf("rnd%0d.done", c), done, exp_done);
            chk($sformatf("rnd%0d.aborted", c), aborted, exp_ab);
            chk($sformatf("rnd%0d.busy", c), busy, (m_owner < 0) ? 0 : 1);
            chk($sformatf("rnd%0d.remaining", c), remaining, (m_owner < 0) ? 0 : m_left);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
